rally_ctrl: RTL and testbench
=============================

Name: rally_ctrl

Overview:
Game-flow controller for blobby volley. It sequences each point through serve, rally and scoring, gates the ball physics on and off, and requests ball re-spawn on the serving side. It enforces the touch limit and keeps both scores. It sits in the pclk (65 MHz) domain beside the ball/player draw pipeline, takes its frame timing from the vga_timing vblnk signal, and takes collision events from the ball physics block.

Parameters:
WIN_SCORE, 15, points needed to win the game (1..15)
SERVE_FRAMES, 60, frames the ball is held before a rally starts (1..255)
POINT_FRAMES, 90, frames of pause after a point is scored (1..255)
MAX_TOUCHES, 3, touches allowed per side before a fault (1..7)

Ports:
pclk  in  1  pixel clock, the only clock
rst  in  1  synchronous, active-high reset
vblnk_in  in  1  vertical blank from vga_timing
start  in  1  start/restart request, level or pulse
ball_grounded  in  1  one-cycle pulse: ball touched the floor
ball_side  in  1  side of the ball at a grounded event (0 = left/P1, 1 = right/P2)
touch_p1  in  1  one-cycle pulse: P1 blob hit the ball
touch_p2  in  1  one-cycle pulse: P2 blob hit the ball
phys_en  out  1  ball physics update enable
ball_reset  out  1  one-cycle pulse: re-spawn the ball above serve_side
serve_side  out  1  side that serves next (0 = P1, 1 = P2)
score_p1  out  4  P1 score
score_p2  out  4  P2 score
state  out  3  current FSM state code
winner  out  2  00 none, 01 P1, 10 P2

Behaviour:
- All outputs are registered. Reset values: state IDLE, scores 0, phys_en 0, ball_reset 0, serve_side 0, winner 00, timer 0, touch_cnt 0, last_side 0.
- frame_tick = vblnk_in & ~vblnk_q. It is a single-cycle pulse once per frame. vblnk_q resets to 0.
- States: IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4. Other codes go to IDLE on the next cycle.
- IDLE:
  - phys_en 0.
  - start=1 -> SERVE. Clear scores, serve_side 0, timer 0, touch_cnt 0, winner 00, ball_reset=1 for exactly that transition cycle.
- SERVE:
  - phys_en 0.
  - timer increments on frame_tick.
  - When timer reaches SERVE_FRAMES-1 and a frame_tick arrives -> RALLY, timer cleared.
  - touch and grounded inputs are ignored.
- RALLY:
  - phys_en 1.
  - Event priority in one cycle: ball_grounded over touches.
  - ball_grounded: scorer = ~ball_side -> POINT.
  - Exactly one touch_pX=1: if X equals last_side and touch_cnt != 0, then touch_cnt+1; otherwise touch_cnt=1 and last_side=X.
  - If the new count exceeds MAX_TOUCHES, it is a fault: scorer = opponent of X -> POINT.
  - touch_p1 and touch_p2 together: ignored, no count change.
- POINT entry (single cycle):
  - Scorer's score +1, saturating at 15.
  - serve_side = scorer; touch_cnt 0; timer 0; phys_en 0.
- POINT:
  - Wait POINT_FRAMES frame_ticks.
  - Then, if the scorer's score >= WIN_SCORE -> OVER with winner set.
  - Otherwise -> SERVE with a one-cycle ball_reset.
- OVER:
  - phys_en 0; scores and winner hold.
  - start=1 -> same action as start in IDLE: new game, SERVE, ball_reset pulse.
- start is ignored in SERVE, RALLY and POINT.
- rst=1 in any state: all registers return to reset values on the next pclk edge, and any ball_reset in progress is dropped.
- Timer is 8 bits, compared with ==, and never wraps in normal operation. A frame_tick arriving in the same cycle as a state entry does not count.
- Latency: every input event is visible on the outputs 1 cycle later.

Decomposition:
- Shared package blobby_pkg:
  - state codes (ST_IDLE..ST_OVER)
  - SIDE_P1/SIDE_P2 constants
  - WINNER_* codes
  - score and timer widths
- One natural sub-module: frame_timer. It contains the vblnk edge detector plus the 8-bit frame counter with clear and a terminal-count compare against a runtime limit. It is instantiated once and shared between SERVE and POINT by muxing the limit.

Test Plan:
1. Reset, then start pulse -> ball_reset=1 for 1 cycle, state=1, phys_en=0. After 60 vblnk rising edges -> state=2, phys_en=1.
2. RALLY, ball_grounded with ball_side=0 -> next cycle state=3, score_p2=1, serve_side=1. After 90 frames -> state=1 and a single-cycle ball_reset.
3. RALLY, four touch_p1 pulses with no touch_p2 -> on the 4th, state=3, score_p2 increments. A touch_p2 between p1 touches resets the count so that no fault occurs.
4. Same-cycle ball_grounded(side=1) and touch_p2 -> point to P1 only, score_p1+1. touch_p1 and touch_p2 together -> no state change.
5. P1 reaches 15 points -> after 90 frames state=4, winner=01, phys_en=0. start -> scores 0, winner 00, state=1.
6. rst asserted during RALLY and during POINT timing -> next cycle all outputs at reset values, state=0. start is ignored while state is 1, 2 or 3.

Source files
------------

// File: rtl/blobby_pkg.sv
// Shared types and constants for the blobby volley game-flow logic.
package blobby_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned TIMER_W = 8;
  localparam int unsigned TOUCH_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_RALLY = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic SIDE_P1 = 1'b0;
  localparam logic SIDE_P2 = 1'b1;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rally_ctrl_if.sv
// Game-flow bus between the playfield logic and rally_ctrl.
interface rally_ctrl_if;
  import blobby_pkg::*;

  logic               vblnk_in;
  logic               start;
  logic               ball_grounded;
  logic               ball_side;
  logic               touch_p1;
  logic               touch_p2;
  logic               phys_en;
  logic               ball_reset;
  logic               serve_side;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [2:0]         state;
  logic [1:0]         winner;

  modport master (
    output vblnk_in, start, ball_grounded, ball_side, touch_p1, touch_p2,
    input  phys_en, ball_reset, serve_side, score_p1, score_p2, state, winner
  );

  modport slave (
    input  vblnk_in, start, ball_grounded, ball_side, touch_p1, touch_p2,
    output phys_en, ball_reset, serve_side, score_p1, score_p2, state, winner
  );
endinterface

// File: rtl/rally_ctrl_frame_timer.sv
// vblnk rising-edge detector plus a frame counter with terminal-count compare.
module frame_timer
  import blobby_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               vblnk_in,
  input  logic               run,
  input  logic [TIMER_W-1:0] limit,
  output logic               done
);

  logic               vblnk_q;
  logic [TIMER_W-1:0] count;
  logic               frame_tick;

  assign frame_tick = vblnk_in & ~vblnk_q;
  assign done       = run & frame_tick & (count == limit);

  // Held at zero while not running, so a tick in the entry cycle is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      count   <= '0;
    end else begin
      vblnk_q <= vblnk_in;
      if (!run || done)
        count <= '0;
      else if (frame_tick)
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rally_ctrl.sv
// Blobby volley point sequencer: serve, rally, scoring, touch limit and win detection.
module rally_ctrl
  import blobby_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 15,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned MAX_TOUCHES  = 3
) (
  input  logic         pclk,
  input  logic         rst,
  rally_ctrl_if.slave  bus
);

  state_t             state_q;
  logic               phys_en_q;
  logic               ball_reset_q;
  logic               serve_side_q;
  logic [SCORE_W-1:0] score_p1_q;
  logic [SCORE_W-1:0] score_p2_q;
  logic [1:0]         winner_q;
  logic [TOUCH_W-1:0] touch_cnt_q;
  logic               last_side_q;

  logic               timer_run;
  logic [TIMER_W-1:0] timer_limit;
  logic               timer_done;

  logic               single_touch;
  logic               touch_side;
  logic [TOUCH_W-1:0] touch_next;
  logic               point_now;
  logic               scorer;
  logic [SCORE_W-1:0] scorer_score;

  assign timer_run   = (state_q == ST_SERVE) || (state_q == ST_POINT);
  assign timer_limit = (state_q == ST_POINT) ? TIMER_W'(POINT_FRAMES - 1)
                                             : TIMER_W'(SERVE_FRAMES - 1);

  frame_timer u_frame_timer (
    .clk      (pclk),
    .rst      (rst),
    .vblnk_in (bus.vblnk_in),
    .run      (timer_run),
    .limit    (timer_limit),
    .done     (timer_done)
  );

  // Grounding outranks any touch in the same cycle.
  always_comb begin
    single_touch = bus.touch_p1 ^ bus.touch_p2;
    touch_side   = bus.touch_p2;
    touch_next   = (touch_cnt_q != '0 && touch_side == last_side_q)
                   ? touch_cnt_q + 1'b1 : TOUCH_W'(1);
    point_now    = bus.ball_grounded
                   || (single_touch && (32'(touch_next) > MAX_TOUCHES));
    scorer       = bus.ball_grounded ? ~bus.ball_side : ~touch_side;
    scorer_score = (serve_side_q == SIDE_P2) ? score_p2_q : score_p1_q;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phys_en_q    <= 1'b0;
      ball_reset_q <= 1'b0;
      serve_side_q <= SIDE_P1;
      score_p1_q   <= '0;
      score_p2_q   <= '0;
      winner_q     <= WINNER_NONE;
      touch_cnt_q  <= '0;
      last_side_q  <= SIDE_P1;
    end else begin
      ball_reset_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          phys_en_q <= 1'b0;
          if (bus.start) begin
            state_q      <= ST_SERVE;
            ball_reset_q <= 1'b1;
            serve_side_q <= SIDE_P1;
            score_p1_q   <= '0;
            score_p2_q   <= '0;
            winner_q     <= WINNER_NONE;
            touch_cnt_q  <= '0;
          end
        end
        ST_SERVE: begin
          if (timer_done) begin
            state_q   <= ST_RALLY;
            phys_en_q <= 1'b1;
          end
        end
        ST_RALLY: begin
          if (point_now) begin
            state_q      <= ST_POINT;
            phys_en_q    <= 1'b0;
            serve_side_q <= scorer;
            touch_cnt_q  <= '0;
            if (scorer == SIDE_P1)
              score_p1_q <= sat_inc(score_p1_q);
            else
              score_p2_q <= sat_inc(score_p2_q);
          end else if (single_touch) begin
            touch_cnt_q <= touch_next;
            last_side_q <= touch_side;
          end
        end
        ST_POINT: begin
          if (timer_done) begin
            if (32'(scorer_score) >= WIN_SCORE) begin
              state_q  <= ST_OVER;
              winner_q <= (serve_side_q == SIDE_P2) ? WINNER_P2 : WINNER_P1;
            end else begin
              state_q      <= ST_SERVE;
              ball_reset_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          phys_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.phys_en    = phys_en_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.serve_side = serve_side_q;
  assign bus.score_p1   = score_p1_q;
  assign bus.score_p2   = score_p2_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_rally_ctrl.sv
// Self-checking bench for rally_ctrl: directed flow plus randomized rallies against a list-based touch model.
module tb_rally_ctrl;

  localparam int unsigned WIN     = 15;
  localparam int unsigned SERVE_F = 60;
  localparam int unsigned POINT_F = 90;
  localparam int unsigned MAXT    = 3;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  int   br_cnt  = 0;
  int   exp_s1  = 0;
  int   exp_s2  = 0;
  int   exp_srv = 0;

  rally_ctrl_if bus ();

  rally_ctrl #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SERVE_F),
    .POINT_FRAMES (POINT_F),
    .MAX_TOUCHES  (MAXT)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) if (bus.ball_reset === 1'b1) br_cnt++;

  initial begin
    #10000000;
    $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic frames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.vblnk_in = 1'b1;
      tick(2);
      bus.vblnk_in = 1'b0;
      tick(2);
    end
  endtask

  task automatic touch(input bit p1, input bit p2);
    bus.touch_p1 = p1;
    bus.touch_p2 = p2;
    tick(1);
    bus.touch_p1 = 1'b0;
    bus.touch_p2 = 1'b0;
    tick(1);
  endtask

  task automatic ground(input bit side, input bit p1, input bit p2);
    bus.ball_grounded = 1'b1;
    bus.ball_side     = side;
    bus.touch_p1      = p1;
    bus.touch_p2      = p2;
    tick(1);
    bus.ball_grounded = 1'b0;
    bus.touch_p1      = 1'b0;
    bus.touch_p2      = 1'b0;
    tick(1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  function automatic void model_point(input int who);
    if (who == 0) exp_s1 = (exp_s1 == 15) ? 15 : exp_s1 + 1;
    else          exp_s2 = (exp_s2 == 15) ? 15 : exp_s2 + 1;
    exp_srv = who;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n_total++; if (bus.state !== 3'd0) $display("FAIL rst_state got=%0d exp=0", bus.state); else n_pass++;
    n_total++; if (bus.score_p1 !== 4'd0) $display("FAIL rst_s1 got=%0d exp=0", bus.score_p1); else n_pass++;
    n_total++; if (bus.score_p2 !== 4'd0) $display("FAIL rst_s2 got=%0d exp=0", bus.score_p2); else n_pass++;
    n_total++; if (bus.phys_en !== 1'b0) $display("FAIL rst_phys got=%b exp=0", bus.phys_en); else n_pass++;
    n_total++; if (bus.ball_reset !== 1'b0) $display("FAIL rst_br got=%b exp=0", bus.ball_reset); else n_pass++;
    n_total++; if (bus.serve_side !== 1'b0) $display("FAIL rst_serve got=%b exp=0", bus.serve_side); else n_pass++;
    n_total++; if (bus.winner !== 2'b00) $display("FAIL rst_winner got=%b exp=00", bus.winner); else n_pass++;
    frames(3);
    n_total++; if (bus.state !== 3'd0) $display("FAIL idle_hold got=%0d exp=0", bus.state); else n_pass++;
  endtask

  task automatic test_serve();
    int b0;
    b0 = br_cnt;
    pulse_start();
    n_total++; if (bus.state !== 3'd1) $display("FAIL start_state got=%0d exp=1", bus.state); else n_pass++;
    n_total++; if (bus.ball_reset !== 1'b1) $display("FAIL start_br got=%b exp=1", bus.ball_reset); else n_pass++;
    n_total++; if (bus.phys_en !== 1'b0) $display("FAIL serve_phys got=%b exp=0", bus.phys_en); else n_pass++;
    tick(1);
    n_total++; if (bus.ball_reset !== 1'b0) $display("FAIL br_width got=%b exp=0", bus.ball_reset); else n_pass++;
    frames(30);
    pulse_start();
    n_total++; if (bus.state !== 3'd1) $display("FAIL serve_start_ign got=%0d exp=1", bus.state); else n_pass++;
    frames(SERVE_F - 31);
    n_total++; if (bus.state !== 3'd1) $display("FAIL serve_early got=%0d exp=1", bus.state); else n_pass++;
    frames(1);
    n_total++; if (bus.state !== 3'd2) $display("FAIL serve_done got=%0d exp=2", bus.state); else n_pass++;
    n_total++; if (bus.phys_en !== 1'b1) $display("FAIL rally_phys got=%b exp=1", bus.phys_en); else n_pass++;
    n_total++; if (br_cnt - b0 !== 1) $display("FAIL serve_br_cnt got=%0d exp=1", br_cnt - b0); else n_pass++;
  endtask

  task automatic test_ground_point();
    int b0;
    ground(1'b0, 1'b0, 1'b0);
    model_point(1);
    n_total++; if (bus.state !== 3'd3) $display("FAIL gp_state got=%0d exp=3", bus.state); else n_pass++;
    n_total++; if (bus.score_p2 !== 4'(exp_s2)) $display("FAIL gp_s2 got=%0d exp=%0d", bus.score_p2, exp_s2); else n_pass++;
    n_total++; if (bus.score_p1 !== 4'(exp_s1)) $display("FAIL gp_s1 got=%0d exp=%0d", bus.score_p1, exp_s1); else n_pass++;
    n_total++; if (bus.serve_side !== 1'b1) $display("FAIL gp_serve got=%b exp=1", bus.serve_side); else n_pass++;
    n_total++; if (bus.phys_en !== 1'b0) $display("FAIL gp_phys got=%b exp=0", bus.phys_en); else n_pass++;
    pulse_start();
    n_total++; if (bus.state !== 3'd3) $display("FAIL point_start_ign got=%0d exp=3", bus.state); else n_pass++;
    frames(POINT_F - 1);
    n_total++; if (bus.state !== 3'd3) $display("FAIL point_early got=%0d exp=3", bus.state); else n_pass++;
    b0 = br_cnt;
    frames(1);
    n_total++; if (bus.state !== 3'd1) $display("FAIL point_done got=%0d exp=1", bus.state); else n_pass++;
    n_total++; if (br_cnt - b0 !== 1) $display("FAIL point_br_cnt got=%0d exp=1", br_cnt - b0); else n_pass++;
    frames(SERVE_F);
    n_total++; if (bus.state !== 3'd2) $display("FAIL gp_rally got=%0d exp=2", bus.state); else n_pass++;
  endtask

  task automatic test_touch_fault();
    for (int i = 0; i < 3; i++) touch(1'b1, 1'b0);
    n_total++; if (bus.state !== 3'd2) $display("FAIL tf_three got=%0d exp=2", bus.state); else n_pass++;
    touch(1'b1, 1'b0);
    model_point(1);
    n_total++; if (bus.state !== 3'd3) $display("FAIL tf_fourth got=%0d exp=3", bus.state); else n_pass++;
    n_total++; if (bus.score_p2 !== 4'(exp_s2)) $display("FAIL tf_s2 got=%0d exp=%0d", bus.score_p2, exp_s2); else n_pass++;
    frames(POINT_F);
    frames(SERVE_F);
    touch(1'b1, 1'b0); touch(1'b1, 1'b0); touch(1'b0, 1'b1);
    touch(1'b1, 1'b0); touch(1'b1, 1'b0); touch(1'b1, 1'b0);
    n_total++; if (bus.state !== 3'd2) $display("FAIL tf_interleave got=%0d exp=2", bus.state); else n_pass++;
    ground(1'b1, 1'b0, 1'b0);
    model_point(0);
    n_total++; if (bus.score_p1 !== 4'(exp_s1)) $display("FAIL tf_s1 got=%0d exp=%0d", bus.score_p1, exp_s1); else n_pass++;
    frames(POINT_F);
    frames(SERVE_F);
  endtask

  task automatic test_priority();
    for (int i = 0; i < 3; i++) touch(1'b1, 1'b0);
    touch(1'b1, 1'b1);
    n_total++; if (bus.state !== 3'd2) $display("FAIL pr_both got=%0d exp=2", bus.state); else n_pass++;
    touch(1'b1, 1'b0);
    model_point(1);
    n_total++; if (bus.score_p2 !== 4'(exp_s2)) $display("FAIL pr_count_kept got=%0d exp=%0d", bus.score_p2, exp_s2); else n_pass++;
    frames(POINT_F);
    frames(SERVE_F);
    ground(1'b1, 1'b0, 1'b1);
    model_point(0);
    n_total++; if (bus.state !== 3'd3) $display("FAIL pr_gnd_state got=%0d exp=3", bus.state); else n_pass++;
    n_total++; if (bus.score_p1 !== 4'(exp_s1)) $display("FAIL pr_gnd_s1 got=%0d exp=%0d", bus.score_p1, exp_s1); else n_pass++;
    n_total++; if (bus.score_p2 !== 4'(exp_s2)) $display("FAIL pr_gnd_s2 got=%0d exp=%0d", bus.score_p2, exp_s2); else n_pass++;
    n_total++; if (bus.serve_side !== 1'b0) $display("FAIL pr_gnd_serve got=%b exp=0", bus.serve_side); else n_pass++;
    frames(POINT_F);
    frames(SERVE_F);
  endtask

  // Model: the rally is a list of touch events; a fault is any run of same-side touches longer than MAXT.
  task automatic test_random_rallies();
    for (int r = 0; r < 6; r++) begin
      int  nev, run, who;
      bit  last, prev, side, fault;
      nev = $urandom_range(2, 9);
      run = 0; last = 0; prev = $urandom_range(0, 1); fault = 0; who = 0;
      for (int e = 0; e < nev; e++) begin
        if ($urandom_range(0, 9) == 0) begin
          touch(1'b1, 1'b1);
        end else begin
          side = ($urandom_range(0, 3) == 0) ? ~prev : prev;
          prev = side;
          touch(~side, side);
          if (run > 0 && side == last) run++;
          else begin run = 1; last = side; end
          if (run > int'(MAXT)) begin fault = 1; who = side ? 0 : 1; break; end
        end
        n_total++; if (bus.state !== 3'd2) $display("FAIL rnd_state r=%0d e=%0d got=%0d exp=2", r, e, bus.state); else n_pass++;
      end
      if (!fault) begin
        side = $urandom_range(0, 1);
        prev = $urandom_range(0, 1);
        ground(side, prev, ~prev);
        who = side ? 0 : 1;
      end
      model_point(who);
      n_total++; if (bus.state !== 3'd3) $display("FAIL rnd_point r=%0d got=%0d exp=3", r, bus.state); else n_pass++;
      n_total++; if (bus.score_p1 !== 4'(exp_s1)) $display("FAIL rnd_s1 r=%0d got=%0d exp=%0d", r, bus.score_p1, exp_s1); else n_pass++;
      n_total++; if (bus.score_p2 !== 4'(exp_s2)) $display("FAIL rnd_s2 r=%0d got=%0d exp=%0d", r, bus.score_p2, exp_s2); else n_pass++;
      n_total++; if (bus.serve_side !== 1'(exp_srv)) $display("FAIL rnd_serve r=%0d got=%b exp=%0d", r, bus.serve_side, exp_srv); else n_pass++;
      frames(POINT_F);
      n_total++; if (bus.state !== 3'd1) $display("FAIL rnd_serve_state r=%0d got=%0d exp=1", r, bus.state); else n_pass++;
      frames(SERVE_F);
    end
  endtask

  task automatic test_game_over();
    int b0;
    while (exp_s1 < int'(WIN)) begin
      ground(1'b1, 1'b0, 1'b0);
      model_point(0);
      n_total++; if (bus.score_p1 !== 4'(exp_s1)) $display("FAIL go_s1 got=%0d exp=%0d", bus.score_p1, exp_s1); else n_pass++;
      if (exp_s1 < int'(WIN)) begin
        frames(POINT_F);
        frames(SERVE_F);
      end
    end
    b0 = br_cnt;
    frames(POINT_F - 1);
    n_total++; if (bus.state !== 3'd3) $display("FAIL go_early got=%0d exp=3", bus.state); else n_pass++;
    frames(1);
    n_total++; if (bus.state !== 3'd4) $display("FAIL go_state got=%0d exp=4", bus.state); else n_pass++;
    n_total++; if (bus.winner !== 2'b01) $display("FAIL go_winner got=%b exp=01", bus.winner); else n_pass++;
    n_total++; if (bus.phys_en !== 1'b0) $display("FAIL go_phys got=%b exp=0", bus.phys_en); else n_pass++;
    n_total++; if (br_cnt - b0 !== 0) $display("FAIL go_no_br got=%0d exp=0", br_cnt - b0); else n_pass++;
    frames(5);
    n_total++; if (bus.score_p2 !== 4'(exp_s2)) $display("FAIL go_s2_hold got=%0d exp=%0d", bus.score_p2, exp_s2); else n_pass++;
    n_total++; if (bus.state !== 3'd4) $display("FAIL go_hold got=%0d exp=4", bus.state); else n_pass++;
    pulse_start();
    exp_s1 = 0; exp_s2 = 0; exp_srv = 0;
    n_total++; if (bus.state !== 3'd1) $display("FAIL rs_state got=%0d exp=1", bus.state); else n_pass++;
    n_total++; if (bus.score_p1 !== 4'd0) $display("FAIL rs_s1 got=%0d exp=0", bus.score_p1); else n_pass++;
    n_total++; if (bus.score_p2 !== 4'd0) $display("FAIL rs_s2 got=%0d exp=0", bus.score_p2); else n_pass++;
    n_total++; if (bus.winner !== 2'b00) $display("FAIL rs_winner got=%b exp=00", bus.winner); else n_pass++;
    n_total++; if (bus.ball_reset !== 1'b1) $display("FAIL rs_br got=%b exp=1", bus.ball_reset); else n_pass++;
    frames(SERVE_F);
    n_total++; if (bus.state !== 3'd2) $display("FAIL rs_rally got=%0d exp=2", bus.state); else n_pass++;
  endtask

  task automatic test_reset_midway();
    ground(1'b0, 1'b0, 1'b0);
    frames(40);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_total++; if (bus.state !== 3'd0) $display("FAIL rp_state got=%0d exp=0", bus.state); else n_pass++;
    n_total++; if (bus.score_p2 !== 4'd0) $display("FAIL rp_s2 got=%0d exp=0", bus.score_p2); else n_pass++;
    n_total++; if (bus.serve_side !== 1'b0) $display("FAIL rp_serve got=%b exp=0", bus.serve_side); else n_pass++;
    pulse_start();
    frames(SERVE_F - 1);
    n_total++; if (bus.state !== 3'd1) $display("FAIL rr_serve got=%0d exp=1", bus.state); else n_pass++;
    frames(1);
    n_total++; if (bus.state !== 3'd2) $display("FAIL rr_rally got=%0d exp=2", bus.state); else n_pass++;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_total++; if (bus.state !== 3'd0) $display("FAIL rr_state got=%0d exp=0", bus.state); else n_pass++;
    n_total++; if (bus.phys_en !== 1'b0) $display("FAIL rr_phys got=%b exp=0", bus.phys_en); else n_pass++;
    rst = 1'b1;
    bus.start = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.start = 1'b0;
    n_total++; if (bus.ball_reset !== 1'b0) $display("FAIL rb_br got=%b exp=0", bus.ball_reset); else n_pass++;
    n_total++; if (bus.state !== 3'd0) $display("FAIL rb_state got=%0d exp=0", bus.state); else n_pass++;
  endtask

  initial begin
    bus.vblnk_in      = 1'b0;
    bus.start         = 1'b0;
    bus.ball_grounded = 1'b0;
    bus.ball_side     = 1'b0;
    bus.touch_p1      = 1'b0;
    bus.touch_p2      = 1'b0;
    test_reset();
    test_serve();
    test_ground_point();
    test_touch_fault();
    test_priority();
    test_random_rallies();
    test_game_over();
    test_reset_midway();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
